// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, memory port and register writes.
// Optional memory wait states are enabled with `define MEM_WAIT_EN.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_update,
   output logic       branch,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       adr_src,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] imm_src,
   output logic       illegal_op
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   state_t state, next_state;
   logic   mem_done;

`ifdef MEM_WAIT_EN
   assign mem_done = mem_ready;
`else
   // Single-cycle memory: the ready handshake is always satisfied.
   assign mem_done = mem_ready | 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= next_state;
   end

   // Outputs are forced to zero while reset is held so no strobe escapes mid-abort.
   always_comb begin
      next_state = state;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 2'b00;
      illegal_op = 1'b0;
      if (!reset) begin
         case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
         endcase
         case (state)
            S_FETCH: begin
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               if (mem_done) begin
                  ir_write   = 1'b1;
                  pc_update  = 1'b1;
                  next_state = S_DECODE;
               end
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               case (op)
                  OP_LW, OP_SW: next_state = S_MEMADR;
                  OP_R:         next_state = S_EXECUTER;
                  OP_I:         next_state = S_EXECUTEI;
                  OP_BEQ:       next_state = S_BEQ;
                  OP_JAL:       next_state = S_JAL;
                  default: begin
                     illegal_op = 1'b1;
                     next_state = S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               alu_src_a  = 2'b10;
               alu_src_b  = 2'b01;
               next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
               adr_src = 1'b1;
               if (mem_done)
                  next_state = S_MEMWB;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
               next_state = S_FETCH;
            end
            S_MEMWRITE: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
               if (mem_done)
                  next_state = S_FETCH;
            end
            S_EXECUTER: begin
               alu_src_a  = 2'b10;
               alu_op     = 2'b10;
               next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
               alu_src_a  = 2'b10;
               alu_src_b  = 2'b01;
               alu_op     = 2'b10;
               next_state = S_ALUWB;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               next_state = S_FETCH;
            end
            S_BEQ: begin
               alu_src_a  = 2'b10;
               alu_op     = 2'b01;
               branch     = 1'b1;
               next_state = S_FETCH;
            end
            S_JAL: begin
               alu_src_a  = 2'b01;
               alu_src_b  = 2'b10;
               pc_update  = 1'b1;
               next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
         endcase
      end
   end

   assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors go through a scoreboard queue.
// Build with +define+MEM_WAIT_EN to exercise the wait-state variant.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MWR = 5;
   localparam int ER = 6, EI = 7, AW = 8, BQ = 9, JL = 10;

   typedef struct {
      logic [6:0]  op;
      logic        zero;
      logic        ready;
      logic [17:0] vec;
      string       tag;
   } entry_t;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [6:0] op;
   logic       pc_write, pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [17:0] got;

   entry_t sb[$];
   int checks = 0;
   int passed = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
      .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_src(imm_src), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign got = {pc_write, pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal_op,
                 result_src, alu_src_a, alu_src_b, alu_op, imm_src};

   function automatic logic [1:0] exp_imm(input logic [6:0] o);
      if (o == OP_SW)  return 2'b01;
      if (o == OP_BEQ) return 2'b10;
      if (o == OP_JAL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [17:0] exp_vec(input int st, input logic [6:0] o, input logic z, input logic rdy);
      logic pcw, pcu, br, irw, rw, mw, adr, ill;
      logic [1:0] res, sa, sb2, aop;
      {pcw, pcu, br, irw, rw, mw, adr, ill} = 8'b0;
      {res, sa, sb2, aop} = 8'b0;
      case (st)
         F: begin
            sb2 = 2'b10; res = 2'b10;
`ifdef MEM_WAIT_EN
            if (rdy) begin irw = 1'b1; pcu = 1'b1; pcw = 1'b1; end
`else
            irw = 1'b1; pcu = 1'b1; pcw = 1'b1;
`endif
         end
         D: begin
            sa = 2'b01; sb2 = 2'b01;
            ill = !(o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL);
         end
         MA:  begin sa = 2'b10; sb2 = 2'b01; end
         MR:  adr = 1'b1;
         MWB: begin res = 2'b01; rw = 1'b1; end
         MWR: begin adr = 1'b1; mw = 1'b1; end
         ER:  begin sa = 2'b10; aop = 2'b10; end
         EI:  begin sa = 2'b10; sb2 = 2'b01; aop = 2'b10; end
         AW:  rw = 1'b1;
         BQ:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; pcw = z; end
         JL:  begin sa = 2'b01; sb2 = 2'b10; pcu = 1'b1; pcw = 1'b1; end
         default: ;
      endcase
      return {pcw, pcu, br, irw, rw, mw, adr, ill, res, sa, sb2, aop, exp_imm(o)};
   endfunction

   task automatic push_state(input int st, input logic [6:0] o, input logic z, input logic rdy, input string tag);
      entry_t e;
      e.op = o; e.zero = z; e.ready = rdy; e.vec = exp_vec(st, o, z, rdy);
      e.tag = $sformatf("%s_s%0d", tag, st);
      sb.push_back(e);
   endtask

   task automatic push_instr(input logic [6:0] o, input logic z, input string tag);
      int seq[$];
      case (o)
         OP_LW:   seq = '{F, D, MA, MR, MWB};
         OP_SW:   seq = '{F, D, MA, MWR};
         OP_R:    seq = '{F, D, ER, AW};
         OP_I:    seq = '{F, D, EI, AW};
         OP_BEQ:  seq = '{F, D, BQ};
         OP_JAL:  seq = '{F, D, JL, AW};
         default: seq = '{F, D};
      endcase
      foreach (seq[i]) push_state(seq[i], o, z, 1'b1, tag);
   endtask

   task automatic test_reset();
      reset = 1'b1; op = OP_SW; zero = 1'b1; mem_ready = 1'b1;
      #2;
      checks++;
      if (got !== 18'h0) $display("[TB] FAIL reset_outputs got %h want %h", got, 18'h0);
      else passed++;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got !== 18'h0) $display("[TB] FAIL reset_held got %h want %h", got, 18'h0);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_lw();
      entry_t e;
      push_instr(OP_LW, 1'b0, "lw");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; zero = e.zero; mem_ready = e.ready;
         @(negedge clk);
         checks++;
         if (got !== e.vec) $display("[TB] FAIL %s got %h want %h", e.tag, got, e.vec);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_alu();
      entry_t e;
      push_instr(OP_SW, 1'b1, "sw");
      push_instr(OP_R, 1'b1, "rtype");
      push_instr(OP_I, 1'b0, "itype");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; zero = e.zero; mem_ready = e.ready;
         @(negedge clk);
         checks++;
         if (got !== e.vec) $display("[TB] FAIL %s got %h want %h", e.tag, got, e.vec);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_jump();
      entry_t e;
      push_instr(OP_BEQ, 1'b1, "beq_taken");
      push_instr(OP_BEQ, 1'b0, "beq_not");
      push_instr(OP_JAL, 1'b0, "jal");
      push_instr(OP_BAD, 1'b0, "illegal");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; zero = e.zero; mem_ready = e.ready;
         @(negedge clk);
         checks++;
         if (got !== e.vec) $display("[TB] FAIL %s got %h want %h", e.tag, got, e.vec);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_ready();
      entry_t e;
`ifdef MEM_WAIT_EN
      for (int i = 0; i < 3; i++) push_state(F, OP_LW, 1'b0, 1'b0, "fetch_wait");
      push_instr(OP_LW, 1'b0, "lw_after_wait");
      push_state(F, OP_SW, 1'b0, 1'b1, "sw_wait");
      push_state(D, OP_SW, 1'b0, 1'b1, "sw_wait");
      push_state(MA, OP_SW, 1'b0, 1'b1, "sw_wait");
      push_state(MWR, OP_SW, 1'b0, 1'b0, "sw_hold");
      push_state(MWR, OP_SW, 1'b0, 1'b0, "sw_hold");
      push_state(MWR, OP_SW, 1'b0, 1'b1, "sw_done");
`else
      for (int i = 0; i < 5; i++) push_state(i == 0 ? F : i == 1 ? D : i == 2 ? MA : i == 3 ? MR : MWB,
                                             OP_LW, 1'b0, 1'b0, "lw_ready_ignored");
`endif
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; zero = e.zero; mem_ready = e.ready;
         @(negedge clk);
         checks++;
         if (got !== e.vec) $display("[TB] FAIL %s got %h want %h", e.tag, got, e.vec);
         else passed++;
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      entry_t e;
      push_instr(OP_SW, 1'b0, "sw_abort");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; zero = e.zero; mem_ready = e.ready;
         @(negedge clk);
         checks++;
         if (got !== e.vec) $display("[TB] FAIL %s got %h want %h", e.tag, got, e.vec);
         else passed++;
         if (sb.size() > 0) begin
            @(posedge clk); #1;
         end
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (mem_write !== 1'b0) $display("[TB] FAIL abort_mem_write got %b want 0", mem_write);
      else passed++;
      checks++;
      if (got !== 18'h0) $display("[TB] FAIL abort_outputs got %h want %h", got, 18'h0);
      else passed++;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      entry_t e;
      push_instr(OP_JAL, 1'b1, "b2b_jal");
      push_instr(OP_LW, 1'b1, "b2b_lw");
      push_instr(OP_BEQ, 1'b1, "b2b_beq");
      push_instr(OP_R, 1'b0, "b2b_r");
      push_state(F, OP_SW, 1'b0, 1'b1, "b2b_end");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; zero = e.zero; mem_ready = e.ready;
         @(negedge clk);
         checks++;
         if (got !== e.vec) $display("[TB] FAIL %s got %h want %h", e.tag, got, e.vec);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_alu();
      test_branch_jump();
      test_mem_ready();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
